// File: rtl/hlpte_param_sched.sv
// HLPTE parameter scheduler: FIFOs host parameter sets and issues them to
// the engine one at a time, counting result beats with a stall watchdog.
module hlpte_param_sched #(
    parameter int DEPTH   = 4,
    parameter int BEATS   = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_index,
    input  logic       cmd_mode,
    input  logic [4:0] cmd_qp,
    input  logic       img_ready,
    output logic       prm_valid,
    output logic [3:0] prm_index,
    output logic       prm_mode,
    output logic [4:0] prm_qp,
    input  logic       eng_out_valid,
    output logic       set_done,
    output logic [7:0] sets_done,
    output logic       busy,
    output logic       err_timeout,
    input  logic       err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BEATS + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t        state, state_d;
    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [BW-1:0] beat_cnt;
    logic [WW-1:0] wd_cnt;

    logic       push, pop, can_issue, beat, last_beat, wd_hit;
    logic       prm_valid_d, set_done_d, busy_d, err_d;
    logic [9:0] prm_d;
    logic [7:0] sets_done_d;

    assign cmd_ready = (count < CW'(DEPTH)) && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ISSUE);
    assign can_issue = (count != '0) && img_ready && !err_timeout;
    assign beat      = (state == WAIT) && eng_out_valid;
    assign last_beat = beat && (beat_cnt == BW'(BEATS - 1));
    // Fires on the TIMEOUT-th consecutive beatless WAIT cycle.
    assign wd_hit    = (state == WAIT) && !eng_out_valid &&
                       (wd_cnt == WW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  if (can_issue) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (wd_hit)         state_d = IDLE;
                else if (last_beat) state_d = GAP;
            end
            GAP:   state_d = can_issue ? ISSUE : IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered.
    always_comb begin
        prm_valid_d = (state_d == ISSUE);
        prm_d       = prm_valid_d ? mem[rd_ptr] : '0;
        set_done_d  = (state_d == GAP);
        busy_d      = (state_d != IDLE);
        sets_done_d = set_done_d ? sets_done + 8'd1 : sets_done;
        err_d       = wd_hit ? 1'b1 : (err_clr ? 1'b0 : err_timeout);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prm_valid   <= 1'b0;
            prm_index   <= '0;
            prm_mode    <= 1'b0;
            prm_qp      <= '0;
            set_done    <= 1'b0;
            sets_done   <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            prm_valid   <= prm_valid_d;
            prm_index   <= prm_d[9:6];
            prm_mode    <= prm_d[5];
            prm_qp      <= prm_d[4:0];
            set_done    <= set_done_d;
            sets_done   <= sets_done_d;
            busy        <= busy_d;
            err_timeout <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_index, cmd_mode, cmd_qp};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            wd_cnt   <= '0;
        end else if (state == ISSUE) begin
            beat_cnt <= '0;
            wd_cnt   <= '0;
        end else if (state == WAIT) begin
            if (beat) begin
                beat_cnt <= beat_cnt + BW'(1);
                wd_cnt   <= '0;
            end else if (wd_cnt < WW'(TIMEOUT)) begin
                wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end
endmodule

// File: tb/tb_hlpte_param_sched.sv
// Scoreboard bench for hlpte_param_sched: transaction-level reference model
// with directed latency, spacing, timeout, reset and wrap scenarios.
module tb_hlpte_param_sched;
    localparam int DEPTH   = 4;
    localparam int BEATS   = 16;
    localparam int TIMEOUT = 1023;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready, cmd_mode;
    logic [3:0] cmd_index;
    logic [4:0] cmd_qp;
    logic       img_ready, prm_valid, prm_mode;
    logic [3:0] prm_index;
    logic [4:0] prm_qp;
    logic       eng_out_valid, set_done, busy, err_timeout, err_clr;
    logic [7:0] sets_done;

    hlpte_param_sched #(
        .DEPTH(DEPTH), .BEATS(BEATS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_index(cmd_index), .cmd_mode(cmd_mode), .cmd_qp(cmd_qp),
        .img_ready(img_ready),
        .prm_valid(prm_valid), .prm_index(prm_index),
        .prm_mode(prm_mode), .prm_qp(prm_qp),
        .eng_out_valid(eng_out_valid),
        .set_done(set_done), .sets_done(sets_done),
        .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
    );

    typedef struct packed {
        logic [3:0] idx;
        logic       mode;
        logic [4:0] qp;
    } prm_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   beat_mode = 0;
    int   done_pulses = 0;
    bit   mon_on = 0;
    prm_t exp_q[$];
    int   issue_t[$];
    bit   m_active, m_err, m_done;
    int   m_beats, m_idle;
    logic [7:0] m_cnt;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        eng_out_valid = 0;
        forever begin
            @(posedge clk);
            #2;
            case (beat_mode)
                0:       eng_out_valid = 0;
                1:       eng_out_valid = 1;
                default: eng_out_valid = ($urandom % 4) != 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO as a queue, a set completes on its BEATS-th
    // beat after the strobe, a stall of TIMEOUT beatless cycles aborts it.
    always @(negedge clk) begin : mon
        int   occ;
        bit   was_act, to, nx_done, nx_err;
        logic [7:0] nx_cnt;
        prm_t e;
        if (mon_on) begin
            occ = exp_q.size();
            was_act = m_active;
            chk("cmd_ready", cmd_ready, (occ < DEPTH) && !rst);
            chk("set_done", set_done, m_done);
            chk("sets_done", sets_done, m_cnt);
            chk("err_timeout", err_timeout, m_err);
            nx_done = 0;
            nx_cnt = m_cnt;
            to = 0;
            if (m_active) begin
                if (eng_out_valid) begin
                    m_beats++;
                    m_idle = 0;
                    if (m_beats == BEATS) begin
                        m_active = 0;
                        nx_done = 1;
                        nx_cnt = m_cnt + 8'd1;
                    end
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_active = 0;
                        to = 1;
                    end
                end
            end
            nx_err = to ? 1'b1 : (err_clr ? 1'b0 : m_err);
            if (prm_valid) begin
                chk("issue_legal",
                    {28'd0, was_act, m_err, m_done, occ == 0}, 0);
                if (occ != 0) begin
                    e = exp_q.pop_front();
                    chk("prm_index", prm_index, e.idx);
                    chk("prm_mode", prm_mode, e.mode);
                    chk("prm_qp", prm_qp, e.qp);
                end
                m_active = 1;
                m_beats = 0;
                m_idle = 0;
                issue_t.push_back(cyc + 1);
            end else begin
                chk("prm_zero", {prm_index, prm_mode, prm_qp}, 0);
            end
            if (cmd_valid && occ < DEPTH && !rst)
                exp_q.push_back('{cmd_index, cmd_mode, cmd_qp});
            if (set_done) done_pulses++;
            if (rst) begin
                exp_q.delete();
                m_active = 0;
                nx_done = 0;
                nx_cnt = 0;
                nx_err = 0;
            end
            m_done = nx_done;
            m_cnt = nx_cnt;
            m_err = nx_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] i, input logic m,
                        input logic [4:0] q);
        cmd_valid = 1;
        cmd_index = i;
        cmd_mode = m;
        cmd_qp = q;
        tick();
        cmd_valid = 0;
    endtask

    task automatic push_rand();
        push(4'($urandom), 1'($urandom), 5'($urandom_range(0, 29)));
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return prm_valid;
            1:       return set_done;
            2:       return err_timeout;
            default: return !busy && exp_q.size() == 0;
        endcase
    endfunction

    task automatic wait_for(input int w, input int lim, input string name,
                            output int n);
        n = 0;
        while (!sig(w) && n < lim) begin
            tick();
            n++;
        end
        chk({name, "_seen"}, sig(w), 1);
    endtask

    initial begin
        int n, s0, base, pushed;
        rst = 1; cmd_valid = 0; cmd_index = 0; cmd_mode = 0;
        cmd_qp = 0; img_ready = 0; err_clr = 0;
        m_active = 0; m_err = 0; m_done = 0;
        m_beats = 0; m_idle = 0; m_cnt = 0;
        tick();
        mon_on = 1;
        tick();
        tick();
        rst = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_prm_valid", prm_valid, 0);
        chk("rst_ready", cmd_ready, 1);

        // single set with two-cycle issue latency
        img_ready = 1;
        push(4'd3, 1'b1, 5'd12);
        wait_for(0, 20, "t1_prm", n);
        chk("t1_latency", n, 1);
        chk("t1_payload", {prm_index, prm_mode, prm_qp}, {4'd3, 1'b1, 5'd12});
        beat_mode = 1;
        wait_for(1, 40, "t1_done", n);
        chk("t1_sets_done", sets_done, 1);
        tick();
        chk("t1_busy", busy, 0);
        beat_mode = 0;

        // fill FIFO, refuse fifth, issue spacing
        img_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t2_ready_free", cmd_ready, 1);
            push(4'(i + 5), 1'(i), 5'(i * 7));
        end
        chk("t2_ready_full", cmd_ready, 0);
        push(4'd15, 1'b1, 5'd29);
        issue_t.delete();
        img_ready = 1;
        beat_mode = 1;
        wait_for(3, 200, "t2_drain", n);
        chk("t2_issues", issue_t.size(), DEPTH);
        for (int i = 1; i < issue_t.size(); i++)
            chk("t2_spacing", issue_t[i] - issue_t[i-1], BEATS + 2);
        beat_mode = 0;

        // push during ISSUE: refused when full, count kept at 3
        img_ready = 0;
        for (int i = 0; i < DEPTH; i++) push_rand();
        img_ready = 1;
        wait_for(0, 10, "t3_prm", n);
        chk("t3_ready_issue_full", cmd_ready, 0);
        push_rand();
        beat_mode = 1;
        wait_for(1, 40, "t3_done", n);
        wait_for(0, 10, "t3_prm2", n);
        chk("t3_ready_issue3", cmd_ready, 1);
        push_rand();
        chk("t3_ready_after", cmd_ready, 1);
        push_rand();
        chk("t3_ready_full", cmd_ready, 0);
        wait_for(3, 300, "t3_drain", n);
        beat_mode = 0;

        // watchdog: 5 beats then stall
        push_rand();
        push_rand();
        wait_for(0, 10, "t4_prm", n);
        tick();
        beat_mode = 1;
        repeat (5) tick();
        beat_mode = 0;
        wait_for(2, TIMEOUT + 50, "t4_err", n);
        chk("t4_timeout_cycles", n, TIMEOUT);
        chk("t4_busy", busy, 0);
        repeat (20) tick();
        chk("t4_held", cmd_ready, 1);
        err_clr = 1;
        tick();
        err_clr = 0;
        wait_for(0, 10, "t4_reissue", n);
        beat_mode = 1;
        wait_for(3, 100, "t4_drain", n);

        // stray beats while idle
        s0 = sets_done;
        repeat (20) tick();
        chk("t5_stray", sets_done, s0);

        // random traffic
        beat_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom % 3) == 0;
            cmd_index = 4'($urandom);
            cmd_mode = 1'($urandom);
            cmd_qp = 5'($urandom_range(0, 29));
            if ($urandom % 16 == 0) img_ready = ~img_ready;
            tick();
        end
        cmd_valid = 0;
        img_ready = 1;
        beat_mode = 1;
        wait_for(3, 400, "t6_drain", n);

        // reset mid-WAIT flushes everything
        beat_mode = 0;
        img_ready = 0;
        for (int i = 0; i < 3; i++) push_rand();
        img_ready = 1;
        wait_for(0, 10, "t7_prm", n);
        tick();
        tick();
        rst = 1;
        #1;
        chk("t7_ready_rst", cmd_ready, 0);
        tick();
        rst = 0;
        #1;
        chk("t7_outs", {prm_valid, prm_index, prm_mode, prm_qp,
                        set_done, sets_done, busy, err_timeout}, 0);
        chk("t7_ready", cmd_ready, 1);
        repeat (30) tick();
        chk("t7_no_issue", busy, 0);

        // 256 sets wrap the counter
        base = done_pulses;
        beat_mode = 1;
        pushed = 0;
        n = 0;
        while (pushed < 256 && n < 8000) begin
            if (cmd_ready) begin
                cmd_valid = 1;
                cmd_index = 4'($urandom);
                cmd_mode = 1'($urandom);
                cmd_qp = 5'($urandom_range(0, 29));
                pushed++;
            end else begin
                cmd_valid = 0;
            end
            tick();
            n++;
        end
        cmd_valid = 0;
        n = 0;
        while (done_pulses - base < 256 && n < 1000) begin
            tick();
            n++;
        end
        chk("t8_sets", done_pulses - base, 256);
        chk("t8_wrap", sets_done, 0);
        wait_for(3, 100, "t8_drain", n);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
